// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   UART receive engine. Oversamples the asynchronous serial line using the
//   rx_tick enable and assembles LSB-first frames into parallel words. Each
//   word is offered through a valid/ready handshake, together with its
//   framing and parity status. Frames that arrive while a word is still
//   waiting to be accepted are dropped and reported through overrun.
//
// Ports
//   clk        system clock; all logic runs on its rising edge
//   rst        synchronous reset, active-high
//   rx_tick    oversample enable, one clk wide, OVERSAMPLE pulses per bit
//   rxd        asynchronous serial input, idle high
//   rx_ready   consumer accepts rx_data when rx_valid && rx_ready
//   rx_data    received word
//   rx_valid   word available; held until accepted
//   frame_err  stop bit of the presented word was sampled low
//   parity_err parity mismatch on the presented word (0 when PARITY_EN=0)
//   overrun    at least one frame was lost while rx_valid was held
//   busy       receiver is in any state other than IDLE
module uart_rx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t                 state;
    logic                   rxd_m;
    logic                   rxd_s;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_err;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            tcnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            par_err    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;

            // Accept first; a word completing in the same cycle below
            // overrides the clear of rx_valid.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            if (rx_tick) begin
                case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state <= START;
                            tcnt  <= '0;
                        end
                    end
                    START: begin
                        if (tcnt == T_HALF) begin
                            if (rxd_s) begin
                                state <= IDLE;
                            end else begin
                                tcnt    <= '0;
                                bcnt    <= '0;
                                par_err <= 1'b0;
                                state   <= DATA;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tcnt == T_LAST) begin
                            tcnt  <= '0;
                            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                            bcnt  <= bcnt + BW'(1);
                            if (bcnt == B_LAST)
                                state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (tcnt == T_LAST) begin
                            tcnt    <= '0;
                            par_err <= (((^shreg) ^ rxd_s) != ODD);
                            state   <= STOP;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    STOP: begin
                        if (tcnt == T_LAST) begin
                            tcnt <= '0;
                            // Held, unaccepted word wins; the new one is lost.
                            if (rx_valid && !rx_ready) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_data    <= shreg;
                                frame_err  <= ~rxd_s;
                                parity_err <= par_err;
                                rx_valid   <= 1'b1;
                            end
                            state <= rxd_s ? IDLE : BREAK_WAIT;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    BREAK_WAIT: begin
                        if (rxd_s)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- UART receive engine. Converts the asynchronous serial line `rxd` into parallel words.
- Timing comes from the oversampling tick `rx_tick`, a one-`clk`-wide enable pulse produced by the team's baud clock generator. `rx_tick` is not a clock.
- Delivers each received word through a valid/ready handshake and reports framing, parity and overrun status with it.
- Sits between the pad-side `rxd` and the UART register or FIFO layer.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, `rx_tick` pulses per bit period (even, >=4).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- rx_tick  input  1  oversample enable, single-cycle pulse, OVERSAMPLE pulses per bit.
- rxd  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  consumer accepts `rx_data` when `rx_valid` && `rx_ready`.
- rx_data  output  DATA_BITS  received word, LSB first on the line.
- rx_valid  output  1  word available; held until accepted.
- frame_err  output  1  stop bit sampled 0 for the word in `rx_data`.
- parity_err  output  1  parity mismatch for the word in `rx_data`; always 0 when PARITY_EN=0.
- overrun  output  1  at least one frame lost while `rx_valid` was held.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset: clock is `clk`; reset is `rst`, synchronous, active-high.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Tick counter and bit counter go to 0.
  - Both synchronizer flops go to 1.
  - Reset mid-frame abandons the frame; no `rx_valid` is produced for it.
- Synchronizer: `rxd` passes through 2 flops to give `rxd_s`; 2 `clk` latency. The FSM uses only `rxd_s`.
- Tick counter `tcnt`: 0..OVERSAMPLE-1. It advances only on cycles with `rx_tick`=1. Nothing in the FSM changes on non-tick cycles, except the handshake logic.
- IDLE: on a tick with `rxd_s`=0, go to START with `tcnt`=0.
- START: on each tick, increment `tcnt`. At the tick where `tcnt`==OVERSAMPLE/2-1 (mid start bit), sample `rxd_s`:
  - 1 -> glitch; return to IDLE with no status change.
  - 0 -> `tcnt`=0, bit count=0, go to DATA.
- DATA: when `tcnt`==OVERSAMPLE-1 (mid bit):
  - Shift `rxd_s` into the shift register, LSB first; `tcnt`=0; bit count +1.
  - After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at mid bit.
  - Parity error = XOR(data bits, parity bit) != PARITY_ODD.
  - Then go to STOP.
- STOP: sample at mid bit, then present the word:
  - `rx_data` <= shift register; `frame_err` <= ~sample; `parity_err` <= computed value; `rx_valid` <= 1.
  - Stop sample 1 -> go to IDLE immediately (half stop bit). Back-to-back frames are supported.
  - Stop sample 0 -> go to BREAK_WAIT.
- BREAK_WAIT: remain until `rxd_s`==1 on a tick, then go to IDLE. This prevents a break condition from retriggering START.
- Handshake:
  - `rx_valid` && `rx_ready` in a cycle clears `rx_valid` on the next edge, unless a new word completes in that same cycle.
  - `rx_data`, `frame_err` and `parity_err` are stable while `rx_valid`=1 and not accepted.
- Overrun:
  - A word completes while `rx_valid`=1 and `rx_ready`=0 -> the new word is discarded; the old data and flags are kept; `overrun` <= 1.
  - `overrun` clears on the next accepted handshake.
  - Word completes in the same cycle as an accept -> the new word and its flags load, `rx_valid` stays 1, no overrun.
- `busy` is a combinational decode of state != IDLE.
- Sampling point: with OVERSAMPLE=16, the start bit is sampled at tick 7 and each later bit at tick 15 of its period. This gives a constant mid-bit sample.

Test Plan:
- Basic frame. Setup: OVERSAMPLE=16, `rx_tick` every 4 `clk`, `rx_ready`=1. Stimulus: send 0xA5 as 8N1. Response: one `rx_valid` with `rx_data`=0xA5, `frame_err`=0, `parity_err`=0, `busy` low after stop.
- Start-bit glitch. Stimulus: drive `rxd` low for 3 ticks, then high. Response: FSM returns to IDLE, no `rx_valid`, `busy` pulses only during the glitch window.
- Parity. Setup: PARITY_EN=1, PARITY_ODD=0. Stimulus: send 0x03 with parity bit 1. Response: `rx_data`=0x03, `parity_err`=1. Resending with parity bit 0 gives `parity_err`=0.
- Framing and break. Stimulus: send 0x55 with stop bit 0 and hold `rxd` low for 3 bit times. Response: `rx_data`=0x55, `frame_err`=1, no second frame until `rxd` returns high.
- Overrun. Setup: `rx_ready`=0. Stimulus: send 0x11 then 0x22 back-to-back, then raise `rx_ready`. Response: `rx_data`=0x11, `overrun`=1 until accepted, then `rx_valid`=0 and `overrun`=0.
- Reset mid-frame. Stimulus: assert `rst` for 1 cycle during data bit 4, then send 0x3C. Response: all outputs 0 right after reset, then exactly one `rx_valid` with 0x3C.
